// File: rtl/iob_cache_front_end_fifo.sv
// IOb cache front end with a DEPTH-entry request queue. The queue head is
// dispatched to the cache data path or to the control registers; reads complete in order.
module iob_cache_front_end_fifo #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int USE_CTRL = 0,
    parameter int CTRL_AW  = 5
) (
    input  logic                           clk_i,
    input  logic                           arst_i,
    input  logic                           cke_i,
    input  logic                           avalid_i,
    input  logic [USE_CTRL+ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]              wdata_i,
    input  logic [DATA_W/8-1:0]            wstrb_i,
    output logic                           ready_o,
    output logic [DATA_W-1:0]              rdata_o,
    output logic                           rvalid_o,
    output logic                           data_req_o,
    output logic [ADDR_W-1:0]              data_addr_o,
    output logic [DATA_W-1:0]              data_wdata_o,
    output logic [DATA_W/8-1:0]            data_wstrb_o,
    input  logic [DATA_W-1:0]              data_rdata_i,
    input  logic                           data_ack_i,
    output logic                           ctrl_req_o,
    output logic [CTRL_AW-1:0]             ctrl_addr_o,
    input  logic [DATA_W-1:0]              ctrl_rdata_i,
    input  logic                           ctrl_ack_i,
    output logic [$clog2(DEPTH):0]         occupancy_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;
    localparam int IN_AW  = USE_CTRL + ADDR_W;

    // Queue storage carries no reset: entries are only observed while counted.
    logic                is_ctrl_mem [DEPTH];
    logic [ADDR_W-1:0]   addr_mem    [DEPTH];
    logic [DATA_W-1:0]   wdata_mem   [DEPTH];
    logic [STRB_W-1:0]   wstrb_mem   [DEPTH];

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic                vld_p1;
    logic [DATA_W-1:0]   rdata_p1;

    logic                is_ctrl_in;
    logic                head_valid;
    logic                head_is_ctrl;
    logic                head_is_read;
    logic                push;
    logic                pop;
    logic                pop_read;
    logic [DATA_W-1:0]   sel_rdata;

    generate
        if (USE_CTRL != 0) begin : g_ctrl_sel
            assign is_ctrl_in = addr_i[IN_AW-1];
        end else begin : g_no_ctrl_sel
            assign is_ctrl_in = 1'b0;
        end
    endgenerate

    assign head_valid   = (count != '0);
    assign head_is_ctrl = (USE_CTRL != 0) && head_valid && is_ctrl_mem[rd_ptr];
    assign head_is_read = (wstrb_mem[rd_ptr] == '0);

    assign ready_o   = (count < CNT_W'(DEPTH));
    assign push      = cke_i && avalid_i && ready_o;
    // Only the ack of the path the head is waiting on may retire it.
    assign pop       = cke_i && head_valid && (head_is_ctrl ? ctrl_ack_i : data_ack_i);
    assign pop_read  = pop && head_is_read;
    assign sel_rdata = head_is_ctrl ? ctrl_rdata_i : data_rdata_i;

    assign data_req_o   = head_valid && !head_is_ctrl;
    assign ctrl_req_o   = head_is_ctrl;
    assign data_addr_o  = head_valid ? addr_mem[rd_ptr]  : '0;
    assign data_wdata_o = head_valid ? wdata_mem[rd_ptr] : '0;
    assign data_wstrb_o = head_valid ? wstrb_mem[rd_ptr] : '0;

    generate
        if (USE_CTRL != 0) begin : g_ctrl_addr
            assign ctrl_addr_o = head_valid ? addr_mem[rd_ptr][CTRL_AW-1:0] : '0;
        end else begin : g_no_ctrl_addr
            assign ctrl_addr_o = '0;
        end
    endgenerate

    assign occupancy_o = count;
    assign rvalid_o    = vld_p1;
    assign rdata_o     = rdata_p1;

    always_ff @(posedge clk_i) begin
        if (push) begin
            is_ctrl_mem[wr_ptr] <= is_ctrl_in;
            addr_mem[wr_ptr]    <= addr_i[ADDR_W-1:0];
            wdata_mem[wr_ptr]   <= wdata_i;
            wstrb_mem[wr_ptr]   <= wstrb_i;
        end
    end

    // Stage p1: pointer/count update and registered read completion.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else if (cke_i) begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            vld_p1 <= pop_read;
            if (pop_read) begin
                rdata_p1 <= sel_rdata;
            end
        end
    end

endmodule
